// File: rtl/ram_port_arbiter_if.sv
// Bundle of the fetch, data and RAM-side signals around the shared RAM port.
// The slave modport is the arbiter; the master side holds both requesters and the RAM.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) ();
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_stall;

  logic              dm_req;
  logic              dm_we;
  logic [DATA_W-1:0] dm_base;
  logic [5:0]        dm_offset;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_valid;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_stall;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_read;
  logic              ram_write;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_base, dm_offset, dm_wdata, ram_rdata,
    input  if_valid, if_rdata, if_stall, dm_valid, dm_rdata, dm_stall,
           ram_addr, ram_read, ram_write, ram_wdata
  );

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_base, dm_offset, dm_wdata, ram_rdata,
    output if_valid, if_rdata, if_stall, dm_valid, dm_rdata, dm_stall,
           ram_addr, ram_read, ram_write, ram_wdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one single-ported RAM between instruction fetch and the MEM stage.
// Each access runs IDLE -> ACCESS (LATENCY cycles) -> RESPOND, with a starvation guard for fetch.
module ram_port_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int LATENCY      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  ram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPOND
  } state_t;

  state_t            state;
  logic              owner_dm;
  logic [2:0]        lat_cnt;
  logic [2:0]        starve_cnt;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              ram_read_q;
  logic              ram_write_q;
  logic              if_valid_q;
  logic              dm_valid_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;

  logic [ADDR_W-1:0] dm_off_ext;
  logic [ADDR_W-1:0] dm_addr;
  logic              grant_dm;
  logic              grant_if;
  logic              fetch_starved;
  logic              last_beat;

  // Effective address wraps modulo the RAM size by design.
  assign dm_off_ext = ADDR_W'($signed(bus.dm_offset));
  assign dm_addr    = bus.dm_base[ADDR_W-1:0] + dm_off_ext;

  assign fetch_starved = (starve_cnt == 3'(STARVE_LIMIT));
  assign last_beat     = (lat_cnt == 3'(LATENCY - 1));

  // Data normally wins a tie; fetch only jumps ahead once it has waited through STARVE_LIMIT data grants.
  always_comb begin
    grant_dm = 1'b0;
    grant_if = 1'b0;
    if (bus.dm_req && bus.if_req) begin
      if (fetch_starved) grant_if = 1'b1;
      else               grant_dm = 1'b1;
    end else if (bus.dm_req) begin
      grant_dm = 1'b1;
    end else if (bus.if_req) begin
      grant_if = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner_dm    <= 1'b0;
      lat_cnt     <= '0;
      starve_cnt  <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_dm) begin
            owner_dm    <= 1'b1;
            lat_cnt     <= '0;
            ram_addr_q  <= dm_addr;
            ram_wdata_q <= bus.dm_wdata;
            ram_read_q  <= !bus.dm_we;
            ram_write_q <= bus.dm_we;
            if (bus.if_req && !fetch_starved) starve_cnt <= starve_cnt + 3'd1;
            state       <= ACCESS;
          end else if (grant_if) begin
            owner_dm    <= 1'b0;
            lat_cnt     <= '0;
            ram_addr_q  <= bus.if_addr;
            ram_wdata_q <= '0;
            ram_read_q  <= 1'b1;
            ram_write_q <= 1'b0;
            starve_cnt  <= '0;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          if (last_beat) begin
            // Stores leave dm_rdata untouched; only reads capture the RAM word.
            if (ram_read_q) begin
              if (owner_dm) dm_rdata_q <= bus.ram_rdata;
              else          if_rdata_q <= bus.ram_rdata;
            end
            if (owner_dm) dm_valid_q <= 1'b1;
            else          if_valid_q <= 1'b1;
            ram_read_q  <= 1'b0;
            ram_write_q <= 1'b0;
            state       <= RESPOND;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.ram_read  = ram_read_q;
  assign bus.ram_write = ram_write_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.dm_valid  = dm_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_stall  = bus.if_req && !if_valid_q;
  assign bus.dm_stall  = bus.dm_req && !dm_valid_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: one instance at LATENCY=1 and one at LATENCY=3,
// each backed by a small behavioural RAM.
module tb_ram_port_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ram_port_arbiter_if #(.ADDR_W(8), .DATA_W(16)) b1 ();
  ram_port_arbiter_if #(.ADDR_W(8), .DATA_W(16)) b3 ();

  ram_port_arbiter #(.ADDR_W(8), .DATA_W(16), .LATENCY(1), .STARVE_LIMIT(4)) dut1 (
    .clk(clk), .rst(rst), .bus(b1)
  );
  ram_port_arbiter #(.ADDR_W(8), .DATA_W(16), .LATENCY(3), .STARVE_LIMIT(4)) dut3 (
    .clk(clk), .rst(rst), .bus(b3)
  );

  logic [15:0] mem1 [256];
  logic [15:0] mem3 [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: cleared on reset with word 1 preloaded as the fetch target.
  assign b1.ram_rdata = b1.ram_read ? mem1[b1.ram_addr] : 16'h0000;
  assign b3.ram_rdata = b3.ram_read ? mem3[b3.ram_addr] : 16'h0000;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) begin
        mem1[i] <= 16'h0000;
        mem3[i] <= 16'h0000;
      end
      mem1[1] <= 16'h1234;
      mem3[1] <= 16'h1234;
    end else begin
      if (b1.ram_write) mem1[b1.ram_addr] <= b1.ram_wdata;
      if (b3.ram_write) mem3[b3.ram_addr] <= b3.ram_wdata;
    end
  end

  task automatic drive_idle();
    b1.if_req = 0; b1.if_addr = 0; b1.dm_req = 0; b1.dm_we = 0;
    b1.dm_base = 0; b1.dm_offset = 0; b1.dm_wdata = 0;
    b3.if_req = 0; b3.if_addr = 0; b3.dm_req = 0; b3.dm_we = 0;
    b3.dm_base = 0; b3.dm_offset = 0; b3.dm_wdata = 0;
  endtask

  task automatic test_reset();
    logic [61:0] obs;
    rst = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      obs = {b1.if_valid, b1.dm_valid, b1.if_stall, b1.dm_stall, b1.ram_read, b1.ram_write,
             b1.if_rdata, b1.dm_rdata, b1.ram_addr, b1.ram_wdata};
      checks++;
      if (obs !== 62'h0) begin
        errors++;
        $display("[TB] FAIL reset_idle_l1 cycle %0d: got %h expected 0", i, obs);
      end
      obs = {b3.if_valid, b3.dm_valid, b3.if_stall, b3.dm_stall, b3.ram_read, b3.ram_write,
             b3.if_rdata, b3.dm_rdata, b3.ram_addr, b3.ram_wdata};
      checks++;
      if (obs !== 62'h0) begin
        errors++;
        $display("[TB] FAIL reset_idle_l3 cycle %0d: got %h expected 0", i, obs);
      end
    end
  endtask

  task automatic test_store_load();
    @(posedge clk); #1;
    b1.dm_req = 1; b1.dm_we = 1; b1.dm_base = 16'h0002; b1.dm_offset = 6'd1; b1.dm_wdata = 16'h00AB;
    @(negedge clk);
    checks++;
    if ({b1.dm_stall, b1.ram_write} !== 2'b10) begin
      errors++; $display("[TB] FAIL store_t: got %b expected 10", {b1.dm_stall, b1.ram_write});
    end
    @(negedge clk);
    checks++;
    if ({b1.ram_write, b1.ram_read, b1.ram_addr, b1.ram_wdata, b1.dm_valid, b1.dm_stall} !== {2'b10, 8'h03, 16'h00AB, 2'b01}) begin
      errors++; $display("[TB] FAIL store_t1: got w%b r%b a%h d%h v%b s%b expected w1 r0 a03 d00ab v0 s1",
        b1.ram_write, b1.ram_read, b1.ram_addr, b1.ram_wdata, b1.dm_valid, b1.dm_stall);
    end
    @(negedge clk);
    checks++;
    if ({b1.dm_valid, b1.ram_write, b1.dm_stall, b1.if_valid, b1.dm_rdata} !== {4'b1000, 16'h0000}) begin
      errors++; $display("[TB] FAIL store_t2: got v%b w%b s%b iv%b rd%h expected v1 w0 s0 iv0 rd0000",
        b1.dm_valid, b1.ram_write, b1.dm_stall, b1.if_valid, b1.dm_rdata);
    end
    @(posedge clk); #1 b1.dm_req = 0;
    @(posedge clk); #1;
    b1.dm_req = 1; b1.dm_we = 0; b1.dm_wdata = 16'hFFFF;
    @(negedge clk);
    checks++;
    if (b1.dm_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL load_t: dm_valid got %b expected 0", b1.dm_valid);
    end
    @(negedge clk);
    checks++;
    if ({b1.ram_read, b1.ram_write, b1.ram_addr} !== {2'b10, 8'h03}) begin
      errors++; $display("[TB] FAIL load_t1: got r%b w%b a%h expected r1 w0 a03", b1.ram_read, b1.ram_write, b1.ram_addr);
    end
    @(negedge clk);
    checks++;
    if ({b1.dm_valid, b1.if_valid, b1.ram_read, b1.dm_rdata} !== {3'b100, 16'h00AB}) begin
      errors++; $display("[TB] FAIL load_t2: got v%b iv%b r%b rd%h expected v1 iv0 r0 rd00ab",
        b1.dm_valid, b1.if_valid, b1.ram_read, b1.dm_rdata);
    end
    @(posedge clk); #1 b1.dm_req = 0;
  endtask

  task automatic test_fetch();
    @(posedge clk); #1;
    b1.if_req = 1; b1.if_addr = 8'h01;
    @(negedge clk);
    checks++;
    if ({b1.if_stall, b1.ram_read} !== 2'b10) begin
      errors++; $display("[TB] FAIL fetch_t: got s%b r%b expected s1 r0", b1.if_stall, b1.ram_read);
    end
    @(negedge clk);
    checks++;
    if ({b1.if_stall, b1.ram_read, b1.ram_addr} !== {2'b11, 8'h01}) begin
      errors++; $display("[TB] FAIL fetch_t1: got s%b r%b a%h expected s1 r1 a01", b1.if_stall, b1.ram_read, b1.ram_addr);
    end
    @(negedge clk);
    checks++;
    if ({b1.if_valid, b1.if_stall, b1.dm_valid, b1.if_rdata, b1.dm_rdata} !== {3'b100, 16'h1234, 16'h00AB}) begin
      errors++; $display("[TB] FAIL fetch_t2: got v%b s%b dv%b ir%h dr%h expected v1 s0 dv0 ir1234 dr00ab",
        b1.if_valid, b1.if_stall, b1.dm_valid, b1.if_rdata, b1.dm_rdata);
    end
    @(posedge clk); #1 b1.if_req = 0;
  endtask

  task automatic test_offset_wrap();
    logic [15:0] bases [2];
    logic [5:0]  offs  [2];
    logic [7:0]  exp_a [2];
    logic [15:0] datas [2];
    bases = '{16'h0002, 16'h1234};
    offs  = '{6'b111101, 6'b011111};
    exp_a = '{8'hFF, 8'h53};
    datas = '{16'h5A5A, 16'h0F0F};
    for (int v = 0; v < 2; v++) begin
      @(posedge clk); #1;
      b1.dm_req = 1; b1.dm_we = 1; b1.dm_base = bases[v]; b1.dm_offset = offs[v]; b1.dm_wdata = datas[v];
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({b1.ram_write, b1.ram_addr} !== {1'b1, exp_a[v]}) begin
        errors++; $display("[TB] FAIL wrap_addr %0d: got w%b a%h expected w1 a%h", v, b1.ram_write, b1.ram_addr, exp_a[v]);
      end
      @(negedge clk);
      checks++;
      if (b1.dm_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL wrap_valid %0d: got %b expected 1", v, b1.dm_valid);
      end
      @(posedge clk); #1 b1.dm_req = 0;
      checks++;
      if (mem1[exp_a[v]] !== datas[v]) begin
        errors++; $display("[TB] FAIL wrap_mem %0d: got %h expected %h", v, mem1[exp_a[v]], datas[v]);
      end
    end
    b1.dm_we = 0; b1.dm_base = 0; b1.dm_offset = 0;
  endtask

  task automatic test_starvation();
    logic [7:0] seq [6];
    logic [7:0] exp_seq [6];
    int n;
    exp_seq = '{"D", "D", "D", "D", "F", "D"};
    n = 0;
    @(posedge clk); #1;
    b1.if_req = 1; b1.if_addr = 8'h01;
    b1.dm_req = 1; b1.dm_we = 0; b1.dm_base = 16'h0000; b1.dm_offset = 6'd3;
    for (int c = 0; c < 60 && n < 6; c++) begin
      @(negedge clk);
      checks++;
      if ((b1.if_valid && b1.dm_valid) || (b1.ram_read && b1.ram_write)) begin
        errors++; $display("[TB] FAIL starve_excl cycle %0d: got iv%b dv%b r%b w%b expected no overlap",
          c, b1.if_valid, b1.dm_valid, b1.ram_read, b1.ram_write);
      end
      checks++;
      if (b1.if_stall !== !b1.if_valid) begin
        errors++; $display("[TB] FAIL starve_if_stall cycle %0d: got %b expected %b", c, b1.if_stall, !b1.if_valid);
      end
      if (b1.dm_valid) begin
        seq[n] = "D"; n++;
        checks++;
        if (b1.dm_rdata !== 16'h00AB) begin
          errors++; $display("[TB] FAIL starve_dm_rdata: got %h expected 00ab", b1.dm_rdata);
        end
      end else if (b1.if_valid) begin
        seq[n] = "F"; n++;
        checks++;
        if (b1.if_rdata !== 16'h1234) begin
          errors++; $display("[TB] FAIL starve_if_rdata: got %h expected 1234", b1.if_rdata);
        end
      end
    end
    @(posedge clk); #1;
    b1.if_req = 0; b1.dm_req = 0;
    checks++;
    if (n != 6) begin
      errors++; $display("[TB] FAIL starve_timeout: got %0d responses expected 6", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (seq[i] !== exp_seq[i]) begin
        errors++; $display("[TB] FAIL starve_order %0d: got %s expected %s", i, seq[i], exp_seq[i]);
      end
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_hold_after_grant();
    @(posedge clk); #1;
    b3.dm_req = 1; b3.dm_we = 1; b3.dm_base = 16'h0010; b3.dm_offset = 6'd0; b3.dm_wdata = 16'h7777;
    @(negedge clk);
    for (int k = 1; k <= 3; k++) begin
      if (k == 1) begin
        @(posedge clk); #1;
        b3.dm_base = 16'h0020; b3.dm_wdata = 16'h1111;
      end
      @(negedge clk);
      checks++;
      if ({b3.ram_write, b3.ram_addr, b3.ram_wdata, b3.dm_valid, b3.dm_stall} !== {1'b1, 8'h10, 16'h7777, 2'b01}) begin
        errors++; $display("[TB] FAIL hold_access t+%0d: got w%b a%h d%h v%b s%b expected w1 a10 d7777 v0 s1",
          k, b3.ram_write, b3.ram_addr, b3.ram_wdata, b3.dm_valid, b3.dm_stall);
      end
    end
    @(negedge clk);
    checks++;
    if ({b3.dm_valid, b3.ram_write, b3.dm_stall} !== 3'b100) begin
      errors++; $display("[TB] FAIL hold_valid: got v%b w%b s%b expected v1 w0 s0", b3.dm_valid, b3.ram_write, b3.dm_stall);
    end
    @(posedge clk); #1 b3.dm_req = 0;
    checks++;
    if ({mem3[8'h10], mem3[8'h20]} !== {16'h7777, 16'h0000}) begin
      errors++; $display("[TB] FAIL hold_mem: got %h %h expected 7777 0000", mem3[8'h10], mem3[8'h20]);
    end
  endtask

  task automatic test_reset_mid_access();
    @(posedge clk); #1;
    b3.dm_req = 1; b3.dm_we = 1; b3.dm_base = 16'h0040; b3.dm_offset = 6'd0; b3.dm_wdata = 16'hBEEF;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (b3.ram_write !== 1'b1) begin
      errors++; $display("[TB] FAIL midrst_access: ram_write got %b expected 1", b3.ram_write);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; b3.dm_req = 0;
    @(negedge clk);
    checks++;
    if ({b3.ram_write, b3.ram_read, b3.dm_valid} !== 3'b000) begin
      errors++; $display("[TB] FAIL midrst_idle: got w%b r%b v%b expected w0 r0 v0", b3.ram_write, b3.ram_read, b3.dm_valid);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({b3.dm_valid, b3.ram_write} !== 2'b00) begin
        errors++; $display("[TB] FAIL midrst_no_valid cycle %0d: got v%b w%b expected v0 w0", i, b3.dm_valid, b3.ram_write);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_store_load();
    test_fetch();
    test_offset_wrap();
    test_starvation();
    test_hold_after_grant();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
